// File: rtl/vend_if.sv
// Request/response bundle between the vending front panel and vend_controller.
// Requests are single-cycle valid strobes with no ready: the controller samples them every cycle; responses are one-cycle registered pulses.
interface vend_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       select_valid;
  logic [1:0] select_item;
  logic       cancel;
  logic [3:0] stock_available;
  logic [1:0] item_select;
  logic       vend_pulse;
  logic [7:0] credit;
  logic       coin_reject;
  logic       err_sold_out;
  logic       err_funds;
  logic       change_valid;
  logic [1:0] change_code;
  logic       busy;
  logic [1:0] state_dbg;

  modport master (
    output coin_valid, coin_code, select_valid, select_item, cancel, stock_available,
    input  item_select, vend_pulse, credit, coin_reject, err_sold_out, err_funds,
           change_valid, change_code, busy, state_dbg
  );

  modport slave (
    input  coin_valid, coin_code, select_valid, select_item, cancel, stock_available,
    output item_select, vend_pulse, credit, coin_reject, err_sold_out, err_funds,
           change_valid, change_code, busy, state_dbg
  );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction controller: accumulates credit, validates selections,
// issues the vend pulse to the inventory tracker and pays change one coin per cycle.
module vend_controller #(
  parameter int PRICE0     = 75,
  parameter int PRICE1     = 100,
  parameter int PRICE2     = 125,
  parameter int PRICE3     = 150,
  parameter int CREDIT_MAX = 250
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_d;
  logic [1:0] item_d;
  logic [1:0] code_d;
  logic       vend_d, reject_d, sold_d, funds_d, chg_d, busy_d;
  logic       accept;
  logic [8:0] coin_amt, sum, price_sel, price_held, remain, left;

  function automatic logic [8:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = 9'd5;
      2'b01:   coin_value = 9'd10;
      2'b10:   coin_value = 9'd25;
      default: coin_value = 9'd100;
    endcase
  endfunction

  function automatic logic [8:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 9'(PRICE0);
      2'd1:    price_of = 9'(PRICE1);
      2'd2:    price_of = 9'(PRICE2);
      default: price_of = 9'(PRICE3);
    endcase
  endfunction

  // Greedy denomination for the next change coin.
  function automatic logic [1:0] change_for(input logic [8:0] amt);
    if (amt >= 9'd25)      change_for = 2'b10;
    else if (amt >= 9'd10) change_for = 2'b01;
    else                   change_for = 2'b00;
  endfunction

  assign coin_amt   = coin_value(bus.coin_code);
  assign sum        = {1'b0, bus.credit} + coin_amt;
  assign price_sel  = price_of(bus.select_item);
  assign price_held = price_of(bus.item_select);
  assign remain     = {1'b0, bus.credit} - price_held;
  // In CHANGE the credit register still includes the coin shown this cycle.
  assign left       = {1'b0, bus.credit} - coin_value(bus.change_code);

  always_comb begin
    state_d  = state_q;
    credit_d = bus.credit;
    item_d   = bus.item_select;
    code_d   = 2'b00;
    vend_d   = 1'b0;
    reject_d = 1'b0;
    sold_d   = 1'b0;
    funds_d  = 1'b0;
    chg_d    = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        funds_d = bus.select_valid;
        if (bus.coin_valid) begin
          credit_d = coin_amt[7:0];
          state_d  = CREDIT;
        end
      end
      CREDIT: begin
        if (bus.cancel) begin
          state_d  = CHANGE;
          chg_d    = 1'b1;
          code_d   = change_for({1'b0, bus.credit});
          reject_d = bus.coin_valid;
        end else begin
          if (bus.select_valid) begin
            if (!bus.stock_available[bus.select_item]) begin
              sold_d = 1'b1;
            end else if ({1'b0, bus.credit} < price_sel) begin
              funds_d = 1'b1;
            end else begin
              accept   = 1'b1;
              item_d   = bus.select_item;
              vend_d   = 1'b1;
              state_d  = VEND;
              reject_d = bus.coin_valid;
            end
          end
          // A failed select leaves the same-cycle coin to be processed normally.
          if (bus.coin_valid && !accept) begin
            if (sum > 9'(CREDIT_MAX)) reject_d = 1'b1;
            else                      credit_d = sum[7:0];
          end
        end
      end
      VEND: begin
        credit_d = remain[7:0];
        reject_d = bus.coin_valid;
        if (remain != 9'd0) begin
          state_d = CHANGE;
          chg_d   = 1'b1;
          code_d  = change_for(remain);
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        credit_d = left[7:0];
        reject_d = bus.coin_valid;
        if (left != 9'd0) begin
          chg_d  = 1'b1;
          code_d = change_for(left);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      bus.credit       <= 8'd0;
      bus.item_select  <= 2'd0;
      bus.vend_pulse   <= 1'b0;
      bus.coin_reject  <= 1'b0;
      bus.err_sold_out <= 1'b0;
      bus.err_funds    <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.change_code  <= 2'b00;
      bus.busy         <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.credit       <= credit_d;
      bus.item_select  <= item_d;
      bus.vend_pulse   <= vend_d;
      bus.coin_reject  <= reject_d;
      bus.err_sold_out <= sold_d;
      bus.err_funds    <= funds_d;
      bus.change_valid <= chg_d;
      bus.change_code  <= code_d;
      bus.busy         <= busy_d;
    end
  end

  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized plus directed bench for vend_controller; a transaction-level model
// predicts per-cycle response events that a monitor checks in order.
module tb_vend_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;

  vend_if bus();
  vend_controller dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Event word: {stamp[15:0], vend, item[1:0], reject, sold, funds, chg, code[1:0]}
  logic [24:0] exp_q[$];
  logic [8:0]  exp_ev[int];
  localparam logic [8:0] EV_REJ   = 9'h020;
  localparam logic [8:0] EV_SOLD  = 9'h010;
  localparam logic [8:0] EV_FUNDS = 9'h008;

  int m_credit  = 0;
  int busy_from = -1;
  int busy_to   = -1;
  bit mon_en    = 1'b0;
  int price[4]  = '{75, 100, 125, 150};
  int cval[4]   = '{5, 10, 25, 100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add_ev(input int stamp, input logic [8:0] bits);
    if (exp_ev.exists(stamp)) exp_ev[stamp] = exp_ev[stamp] | bits;
    else                      exp_ev[stamp] = bits;
  endfunction

  // Greedy payout starting at cycle 'first'; returns number of coins.
  function automatic int pay_out(input int first, input int amt);
    int s;
    int c;
    logic [1:0] code;
    s = first;
    while (amt > 0) begin
      if (amt >= 25)      begin c = 25; code = 2'b10; end
      else if (amt >= 10) begin c = 10; code = 2'b01; end
      else                begin c = 5;  code = 2'b00; end
      add_ev(s, {6'b000001, code});
      amt = amt - c;
      s++;
    end
    return s - first;
  endfunction

  // Drive one cycle of stimulus (sampled at edge e) and predict its effects.
  task automatic tick(input bit cv, input logic [1:0] cc, input bit sv,
                      input logic [1:0] si, input bit cn, input logic [3:0] stk);
    int e;
    int k;
    bit acc;
    @(negedge clk);
    #1;
    bus.coin_valid      = cv;
    bus.coin_code       = cc;
    bus.select_valid    = sv;
    bus.select_item     = si;
    bus.cancel          = cn;
    bus.stock_available = stk;
    e   = cyc + 1;
    acc = 1'b0;
    if (e - 1 >= busy_from && e - 1 <= busy_to) begin
      if (cv) add_ev(e, EV_REJ);
    end else if (m_credit == 0) begin
      if (cv) m_credit = cval[cc];
      if (sv) add_ev(e, EV_FUNDS);
    end else if (cn) begin
      if (cv) add_ev(e, EV_REJ);
      k = pay_out(e, m_credit);
      busy_from = e;
      busy_to   = e + k - 1;
      m_credit  = 0;
    end else begin
      if (sv) begin
        if (!stk[si]) add_ev(e, EV_SOLD);
        else if (m_credit < price[si]) add_ev(e, EV_FUNDS);
        else begin
          acc = 1'b1;
          add_ev(e, {1'b1, si, 6'b000000});
          k = pay_out(e + 1, m_credit - price[si]);
          busy_from = e;
          busy_to   = e + k;
          m_credit  = 0;
          if (cv) add_ev(e, EV_REJ);
        end
      end
      if (cv && !acc) begin
        if (m_credit + cval[cc] > 250) add_ev(e, EV_REJ);
        else                           m_credit = m_credit + cval[cc];
      end
    end
    if (exp_ev.exists(e)) begin
      exp_q.push_back({e[15:0], exp_ev[e]});
      exp_ev.delete(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 4'hF);
  endtask

  task automatic coin(input logic [1:0] cc);
    tick(1'b1, cc, 1'b0, 2'd0, 1'b0, 4'hF);
  endtask

  task automatic sel(input logic [1:0] si, input logic [3:0] stk);
    tick(1'b0, 2'b00, 1'b1, si, 1'b0, stk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_credit"},      32'(bus.credit), 32'd0);
    check({tag, "_item_select"}, 32'(bus.item_select), 32'd0);
    check({tag, "_vend_pulse"},  32'(bus.vend_pulse), 32'd0);
    check({tag, "_coin_reject"}, 32'(bus.coin_reject), 32'd0);
    check({tag, "_err_sold"},    32'(bus.err_sold_out), 32'd0);
    check({tag, "_err_funds"},   32'(bus.err_funds), 32'd0);
    check({tag, "_change_v"},    32'(bus.change_valid), 32'd0);
    check({tag, "_change_code"}, 32'(bus.change_code), 32'd0);
    check({tag, "_busy"},        32'(bus.busy), 32'd0);
    check({tag, "_state_idle"},  32'(bus.state_dbg), 32'd0);
  endtask

  // Monitor: compares busy/credit every cycle and pops expected events in order.
  always @(negedge clk) begin
    logic [8:0]  ev;
    logic [24:0] w;
    bit          exp_busy;
    if (!rst && mon_en) begin
      ev = {bus.vend_pulse, bus.vend_pulse ? bus.item_select : 2'b00,
            bus.coin_reject, bus.err_sold_out, bus.err_funds,
            bus.change_valid, bus.change_valid ? bus.change_code : 2'b00};
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      if (!exp_busy) check("credit", 32'(bus.credit), 32'(m_credit));
      if (ev != 9'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL event: got unexpected 0x%0h at cycle %0d, expected none", ev, cyc);
        end else begin
          w = exp_q.pop_front();
          check("event", {7'd0, cyc[15:0], ev}, {7'd0, w});
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][24:9]) <= cyc) begin
        w = exp_q.pop_front();
        check("event", {7'd0, cyc[15:0], ev}, {7'd0, w});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.coin_valid      = 1'b0;
    bus.coin_code       = 2'b00;
    bus.select_valid    = 1'b0;
    bus.select_item     = 2'd0;
    bus.cancel          = 1'b0;
    bus.stock_available = 4'hF;
    repeat (3) @(negedge clk);
    check_reset_values("init");
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Select in IDLE, exact payment.
    sel(2'd2, 4'hF);
    coin(2'b10); coin(2'b10); coin(2'b10);
    sel(2'd0, 4'hF);
    idle(3);
    // Overpay with one change coin.
    coin(2'b11);
    sel(2'd0, 4'hF);
    idle(4);
    // Cancel refund of 110.
    coin(2'b11); coin(2'b01);
    tick(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 4'hF);
    idle(7);
    // Errors: funds, sold out, failed select with coin, accepted select with coin.
    coin(2'b10); coin(2'b10);
    sel(2'd1, 4'hF);
    sel(2'd1, 4'b1101);
    tick(1'b1, 2'b10, 1'b1, 2'd2, 1'b0, 4'hF);
    tick(1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 4'hF);
    idle(3);
    // Credit limit, then cancel with coin in the same cycle.
    coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b11); coin(2'b10);
    tick(1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 4'hF);
    idle(12);
    // Long payout, coin while busy, reset mid-change.
    coin(2'b11); coin(2'b11); coin(2'b10);
    sel(2'd1, 4'hF);
    idle(1);
    coin(2'b00);
    tick(1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 4'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.coin_valid   = 1'b0;
    bus.select_valid = 1'b0;
    bus.cancel       = 1'b0;
    #1;
    check_reset_values("midreset");
    m_credit  = 0;
    busy_from = -1;
    busy_to   = -1;
    exp_q.delete();
    exp_ev.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    sel(2'd0, 4'hF);
    idle(2);

    // Random phase.
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0,
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
    end

    n = 0;
    while ((exp_q.size() != 0 || exp_ev.num() != 0 || cyc <= busy_to) && n < 60) begin
      idle(1);
      n++;
    end
    idle(2);
    check("drain", 32'(exp_q.size() + exp_ev.num()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
